uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (tx_start/tx_data/tx_busy) between NREQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Sequences one frame per grant and recovers when tx_busy never rises.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int GNT_W        = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [GNT_W-1:0]  grant_id,
    output logic              arb_busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W-1:0] winner;
    logic [GNT_W-1:0] idx;
    logic             found;
    logic             busy_expired;
    int               sum;

    // First requesting index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        sum    = 0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = GNT_W'(sum);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign busy_expired = (wait_cnt == CNT_W'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (!tx_busy && found) state_next = GRANT;
            GRANT:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)           state_next = WAIT_DONE;
                else if (busy_expired) state_next = IDLE;
            end
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Grant datapath: byte, id and pointer are captured only in the IDLE decision cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            arb_busy <= 1'b0;
        end else begin
            arb_busy <= (state_next != IDLE);
            if (state == IDLE && state_next == GRANT) begin
                tx_data  <= req_data[{winner, 3'b000} +: 8];
                grant_id <= winner;
                rr_ptr   <= (winner == GNT_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == GRANT)          wait_cnt <= '0;
            else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Pulses are suppressed while reset is asserted so an abandoned frame reports nothing.
    always_comb begin
        tx_start    = 1'b0;
        req_ready   = '0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;
        if (!reset) begin
            unique case (state)
                GRANT: begin
                    tx_start  = 1'b1;
                    req_ready = NREQ'(1) << grant_id;
                end
                WAIT_BUSY: timeout_err = !tx_busy && busy_expired;
                WAIT_DONE: frame_done  = !tx_busy;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter/receiver model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GNT_W = 2;
    localparam int BUSY_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic [GNT_W-1:0]  grant_id;
    logic              arb_busy;
    logic              frame_done;
    logic              timeout_err;

    uart_tx_arbiter #(.NREQ(NREQ), .GNT_W(GNT_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .arb_busy(arb_busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: busy rises busy_delay cycles after tx_start and lasts busy_len cycles.
    int   busy_delay = 3;
    int   busy_len = 10;
    bit   never_busy = 1'b0;
    int   dly, len, phase;
    logic [7:0] cap;
    logic [7:0] rx_data = 8'h00;
    int   n_rx = 0;
    int   stable_err = 0;

    always @(negedge clk) begin
        if (reset) begin
            tx_busy = 1'b0;
            phase = 0;
        end else if (phase == 0 && tx_start && !never_busy) begin
            dly = busy_delay;
            len = busy_len;
            cap = tx_data;
            phase = 1;
        end else if (phase == 1) begin
            if (tx_data !== cap) stable_err++;
            dly--;
            if (dly == 0) begin
                tx_busy = 1'b1;
                phase = 2;
            end
        end else if (phase == 2) begin
            if (tx_data !== cap) stable_err++;
            len--;
            if (len == 0) begin
                tx_busy = 1'b0;
                phase = 0;
                rx_data = cap;
                n_rx++;
            end
        end
    end

    // Event monitor, sampled mid-cycle after the model has settled tx_busy.
    int n_start = 0, n_done = 0, n_tmo = 0, n_rdy = 0, n_gap_err = 0;
    int last_fd_cyc = 0, last_tmo_cyc = 0;
    bit have_fd = 1'b0;
    int gnt_log[$];
    int data_log[$];
    int rdy_log[$];
    int cyc_log[$];

    always @(negedge clk) begin
        #1;
        if (tx_start === 1'b1) begin
            n_start++;
            gnt_log.push_back(int'(grant_id));
            data_log.push_back(int'(tx_data));
            rdy_log.push_back(int'(req_ready));
            cyc_log.push_back(cyc);
            if (have_fd && (cyc - last_fd_cyc) < 2) n_gap_err++;
        end
        if (frame_done === 1'b1) begin
            n_done++;
            last_fd_cyc = cyc;
            have_fd = 1'b1;
        end
        if (timeout_err === 1'b1) begin
            n_tmo++;
            last_tmo_cyc = cyc;
        end
        if (|req_ready) n_rdy++;
    end

    function automatic int ev_count(input int kind);
        case (kind)
            0: return n_start;
            1: return n_done;
            2: return n_tmo;
            default: return n_rx;
        endcase
    endfunction

    function automatic int log_at(input int which, input int i);
        case (which)
            0: return (i < gnt_log.size()) ? gnt_log[i] : -1;
            1: return (i < data_log.size()) ? data_log[i] : -1;
            2: return (i < rdy_log.size()) ? rdy_log[i] : -1;
            default: return (i < cyc_log.size()) ? cyc_log[i] : -1;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int kind, input int target, input int budget, input string tag);
        int waited = 0;
        while (ev_count(kind) < target && waited < budget) begin
            tick(1);
            waited++;
        end
        check(tag, 32'(ev_count(kind) >= target), 32'd1);
    endtask

    task automatic do_reset(input int n);
        req_valid = '0;
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    int bs, bd, bt, brx, bse, brdy;
    bit bad;

    initial begin
        // 1: reset holds every output quiet
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (tx_start !== 1'b0 || req_ready !== '0 || frame_done !== 1'b0 ||
                timeout_err !== 1'b0 || arb_busy !== 1'b0 || tx_data !== 8'h00) bad = 1'b1;
        end
        check("rst_quiet", 32'(bad), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        reset = 1'b0;

        // 2: single requester 2
        bs = n_start; bd = n_done; bt = n_tmo;
        req_data[23:16] = 8'h41;
        req_valid = 4'b0100;
        wait_ev(0, bs + 1, 20, "t2_start_seen");
        req_valid = '0;
        wait_ev(1, bd + 1, 60, "t2_done_seen");
        tick(5);
        check("t2_starts", 32'(n_start - bs), 32'd1);
        check("t2_tx_data", 32'(log_at(1, bs)), 32'h41);
        check("t2_req_ready", 32'(log_at(2, bs)), 32'b0100);
        check("t2_grant_id", 32'(log_at(0, bs)), 32'd2);
        check("t2_frame_done", 32'(n_done - bd), 32'd1);
        check("t2_no_timeout", 32'(n_tmo - bt), 32'd0);
        check("t2_rx_data", 32'(rx_data), 32'h41);

        // 3: all four requesting continuously, round-robin order from 0
        do_reset(2);
        bs = n_start; bd = n_done; bse = n_gap_err;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        wait_ev(1, bd + 8, 400, "t3_eight_frames");
        req_valid = '0;
        tick(5);
        check("t3_starts", 32'(n_start - bs), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_grant_%0d", k), 32'(log_at(0, bs + k)), 32'(k % 4));
            check($sformatf("t3_data_%0d", k), 32'(log_at(1, bs + k)), 32'(8'h10 + k % 4));
        end
        check("t3_rdy_onehot_3", 32'(log_at(2, bs + 3)), 32'b1000);
        check("t3_idle_gap", 32'(n_gap_err - bse), 32'd0);

        // 4: transmitter never goes busy
        do_reset(2);
        never_busy = 1'b1;
        bs = n_start; bd = n_done; bt = n_tmo;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        wait_ev(0, bs + 1, 20, "t4_start_seen");
        wait_ev(2, bt + 1, 40, "t4_timeout_seen");
        check("t4_timeout_delay", 32'(last_tmo_cyc - log_at(3, bs)), 32'(BUSY_TIMEOUT));
        wait_ev(0, bs + 2, 20, "t4_regrant_seen");
        req_valid = '0;
        check("t4_regrant_id", 32'(log_at(0, bs + 1)), 32'd0);
        wait_ev(2, bt + 2, 40, "t4_timeout2_seen");
        tick(3);
        check("t4_no_frame_done", 32'(n_done - bd), 32'd0);
        check("t4_timeout_pulses", 32'(n_tmo - bt), 32'd2);
        never_busy = 1'b0;

        // 5: reset during WAIT_DONE abandons the frame and rewinds the pointer
        do_reset(2);
        busy_len = 20;
        bs = n_start; bd = n_done;
        req_data[15:0] = 16'h2221;
        req_valid = 4'b0011;
        wait_ev(0, bs + 1, 20, "t5_start_seen");
        tick(6);
        check("t5_in_frame", 32'({arb_busy, tx_busy}), 32'b11);
        brdy = n_rdy;
        reset = 1'b1;
        tick(1);
        check("t5_rst_outputs", 32'({tx_start, req_ready, frame_done, timeout_err, arb_busy}), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data), 32'h00);
        check("t5_rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        wait_ev(0, bs + 2, 20, "t5_restart_seen");
        req_valid = '0;
        check("t5_first_after_rst", 32'(log_at(0, bs + 1)), 32'd0);
        check("t5_no_ready_in_rst", 32'(n_rdy - brdy), 32'd1);
        wait_ev(1, bd + 1, 80, "t5_done_seen");
        check("t5_one_frame_done", 32'(n_done - bd), 32'd1);
        busy_len = 10;
        tick(3);

        // 6: loopback of 8'h55 from requester 1; source byte changes mid-frame
        bs = n_start; brx = n_rx; bse = stable_err;
        req_data[15:8] = 8'h55;
        req_valid = 4'b0010;
        wait_ev(0, bs + 1, 20, "t6_start_seen");
        req_data[15:8] = 8'hAA;
        req_valid = '0;
        wait_ev(3, brx + 1, 60, "t6_rx_ready");
        check("t6_rx_data", 32'(rx_data), 32'h55);
        check("t6_tx_stable", 32'(stable_err - bse), 32'd0);
        check("t6_tx_data_held", 32'(tx_data), 32'h55);
        check("t6_grant_id", 32'(grant_id), 32'd1);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
